// File: rtl/chip8_pkg.sv
// Shared CHIP-8 keypad constants: matrix geometry, row/column to key-index map, scan column states.
package chip8_pkg;

  localparam int unsigned NUM_KEYS = 16;
  localparam int unsigned KEY_ROWS = 4;
  localparam int unsigned KEY_COLS = 4;

  typedef enum logic [1:0] {Col0, Col1, Col2, Col3} col_e;

  // Physical keypad layout: r0: 1 2 3 C | r1: 4 5 6 D | r2: 7 8 9 E | r3: A 0 B F
  localparam logic [3:0] KEY_MAP [KEY_ROWS][KEY_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hC},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hA, 4'h0, 4'hB, 4'hF}
  };

  // Active-low column drive: only the scanned column is pulled low.
  function automatic logic [KEY_COLS-1:0] col_drive(col_e col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/chip8_keypad_scanner_if.sv
// CPU-facing keypad bus: debounced key state plus the new-press strobe used by Fx0A.
interface chip8_keypad_scanner_if import chip8_pkg::*; ();

  logic [NUM_KEYS-1:0] keys;
  logic                key_pressed;
  logic                press_strobe;
  logic [3:0]          press_code;

  modport master (output keys, output key_pressed, output press_strobe, output press_code);
  modport slave  (input keys, input key_pressed, input press_strobe, input press_code);

endinterface

// File: rtl/chip8_key_debounce.sv
// Per-key debouncer: stable state flips after DEBOUNCE_SCANS consecutive differing samples.
module chip8_key_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [3:0] LastCnt = 4'(DEBOUNCE_SCANS - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       stable_q, stable_d;
  logic       flip;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip     = 1'b0;
    if (sample_en) begin
      if (raw == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == LastCnt) begin
        stable_d = raw;
        cnt_d    = '0;
        flip     = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
  // Asserted during the sample cycle whose closing edge sets the key.
  assign rise   = flip & raw;

endmodule

// File: rtl/chip8_keypad_scanner.sv
// 4x4 CHIP-8 keypad scanner: column drive, row synchroniser, per-key debounce, new-press encoder.
module chip8_keypad_scanner import chip8_pkg::*; #(
  parameter int unsigned SCAN_DIV       = 50_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_ROWS-1:0] row_in,
  output logic [KEY_COLS-1:0] col_out,
  chip8_keypad_scanner_if.master kp
);

  localparam int unsigned       DivW    = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0]   DivLast = DivW'(SCAN_DIV - 1);

  logic [KEY_ROWS-1:0] row_s1_q, row_s2_q, rows;
  logic [DivW-1:0]     div_q, div_d;
  col_e                col_q, col_d;
  logic                sample;

  logic [NUM_KEYS-1:0] stable_rc, rise_rc;
  logic [NUM_KEYS-1:0] keys, rise;
  logic [3:0]          code;
  logic                key_pressed_q, strobe_q;
  logic [3:0]          code_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
    end
  end

  assign rows   = ~row_s2_q;
  assign sample = (div_q == DivLast);

  always_comb begin
    div_d = div_q + DivW'(1);
    col_d = col_q;
    if (sample) begin
      div_d = '0;
      unique case (col_q)
        Col0:    col_d = Col1;
        Col1:    col_d = Col2;
        Col2:    col_d = Col3;
        default: col_d = Col0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      col_q <= Col0;
    end else begin
      div_q <= div_d;
      col_q <= col_d;
    end
  end

  assign col_out = col_drive(col_q);

  for (genvar r = 0; r < KEY_ROWS; r++) begin : g_row
    for (genvar c = 0; c < KEY_COLS; c++) begin : g_col
      chip8_key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample && (col_q == col_e'(c))),
        .raw       (rows[r]),
        .stable    (stable_rc[r*KEY_COLS+c]),
        .rise      (rise_rc[r*KEY_COLS+c])
      );
    end
  end

  // Reorder matrix positions into CHIP-8 key indices.
  always_comb begin
    keys = '0;
    rise = '0;
    for (int r = 0; r < KEY_ROWS; r++) begin
      for (int c = 0; c < KEY_COLS; c++) begin
        keys[KEY_MAP[r][c]] = stable_rc[r*KEY_COLS+c];
        rise[KEY_MAP[r][c]] = rise_rc[r*KEY_COLS+c];
      end
    end
  end

  always_comb begin
    code = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (rise[k]) code = 4'(k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_pressed_q <= 1'b0;
      strobe_q      <= 1'b0;
      code_q        <= '0;
    end else begin
      key_pressed_q <= |keys;
      strobe_q      <= |rise;
      if (|rise) code_q <= code;
    end
  end

  assign kp.keys         = keys;
  assign kp.key_pressed  = key_pressed_q;
  assign kp.press_strobe = strobe_q;
  assign kp.press_code   = code_q;

endmodule
